macrocell_gen: RTL

- Parametrised next-generation CPLD macrocell for the atfsim fabric.
- Generalises the fixed 5-PT, 40-UIM macrocell:
  - configurable product-term count and input widths
  - selectable storage modes (D/T/SR/combinational)
  - clock-enable PT and synchronous clear PT
  - on-chip serial configuration chain with shadow/active double buffering.
- Sits in a logic block beside its siblings; cascade in/out are chained to neighbouring cells.

---
 rtl/macrocell_pkg.sv | 26 ++
 rtl/macrocell_gen_if.sv | 32 +++
 rtl/macrocell_gen_pt_eval.sv | 20 ++
 rtl/macrocell_gen.sv | 114 +++++++++++
 4 files changed

// File: rtl/macrocell_pkg.sv
// Shared definitions for the parametrised atfsim CPLD macrocell:
// storage-mode encodings, output-enable select codes and control-word field offsets.
package macrocell_pkg;

  typedef enum logic [1:0] {
    MODE_D    = 2'b00,
    MODE_T    = 2'b01,
    MODE_SR   = 2'b10,
    MODE_COMB = 2'b11
  } mc_mode_e;

  localparam logic [2:0] OE_ALWAYS = 3'd6;
  localparam logic [2:0] OE_OFF    = 3'd7;

  // Field offsets inside the control word, counted from the bit just above pt_sum_mask
  localparam int CTL_MODE    = 0;
  localparam int CTL_CE      = 2;
  localparam int CTL_SCLR    = 3;
  localparam int CTL_CAS_IN  = 4;
  localparam int CTL_CAS_OUT = 5;
  localparam int CTL_XOR_INV = 6;
  localparam int CTL_FB_SEL  = 7;
  localparam int CTL_OE_SEL  = 8;
  localparam int CTL_TAIL_W  = 11;

endpackage

// File: rtl/macrocell_gen_if.sv
// Signal bundle between a macrocell and its fabric neighbourhood:
// routed inputs, output enables, cascade, configuration chain and cell outputs.
interface macrocell_gen_if #(
  parameter int UIM_W   = 40,
  parameter int FLB_W   = 16,
  parameter int NUM_GOE = 6
);
  logic [UIM_W-1:0]   uim;
  logic [FLB_W-1:0]   in_flb;
  logic [NUM_GOE-1:0] goe;
  logic               casin;
  logic               cfg_shift_en;
  logic               cfg_din;
  logic               cfg_load;
  logic               cfg_dout;
  logic               cfg_valid;
  logic               pad;
  logic               pad_oe;
  logic               mc_fb;
  logic               mc_flb;
  logic               casout;

  modport slave (
    input  uim, in_flb, goe, casin, cfg_shift_en, cfg_din, cfg_load,
    output cfg_dout, cfg_valid, pad, pad_oe, mc_fb, mc_flb, casout
  );

  modport master (
    output uim, in_flb, goe, casin, cfg_shift_en, cfg_din, cfg_load,
    input  cfg_dout, cfg_valid, pad, pad_oe, mc_fb, mc_flb, casout
  );
endinterface

// File: rtl/macrocell_gen_pt_eval.sv
// One product term: AND of every literal whose true or complement fuse is set.
// An unfused term yields 0 so that unused terms never assert the sum.
module pt_eval #(
  parameter int IN_W = 56
) (
  input  logic [2*IN_W-1:0] fuses,
  input  logic [IN_W-1:0]   lits,
  output logic              pt
);

  always_comb begin
    pt = |fuses;
    for (int j = 0; j < IN_W; j++) begin
      if ((fuses[2*j] & ~lits[j]) | (fuses[2*j+1] & lits[j])) begin
        pt = 1'b0;
      end
    end
  end

endmodule

// File: rtl/macrocell_gen.sv
// Parametrised CPLD macrocell with PT array, D/T/SR/comb storage and a shadow/active config chain.
// Define MC_CFG_READBACK_EN to expose shadow[0] on cfg_dout for daisy-chained readback.
module macrocell_gen
  import macrocell_pkg::*;
#(
  parameter int UIM_W   = 40,
  parameter int FLB_W   = 16,
  parameter int NUM_PT  = 5,
  parameter int NUM_GOE = 6
) (
  input  logic            gclk,
  input  logic            gclr,
  macrocell_gen_if.slave  bus
);

  localparam int IN_W  = UIM_W + FLB_W;
  localparam int PT_W  = 2 * IN_W;
  localparam int CTL_W = NUM_PT + 11;
  localparam int CFG_W = NUM_PT * PT_W + CTL_W;

  logic [CFG_W-1:0]      shadow;
  logic [CFG_W-1:0]      active;
  logic                  cfg_valid;

  logic [IN_W-1:0]       lits;
  logic [NUM_PT-1:0]     pt;
  logic [CTL_W-1:0]      ctl;
  logic [NUM_PT-1:0]     sum_mask;
  logic [CTL_TAIL_W-1:0] tail;
  mc_mode_e              mode;
  logic                  ce_en, sclr_en, cas_in_en, cas_out_en, xor_inv, fb_sel;
  logic [2:0]            oe_sel;
  logic [7:0]            oe_tab;
  logic                  sum_raw, local_sum, d, q;

  // Configuration chain: shifting has priority, a load only copies a stable shadow
  always_ff @(posedge gclk or posedge gclr) begin
    if (gclr) begin
      shadow    <= '0;
      active    <= '0;
      cfg_valid <= 1'b0;
    end else if (bus.cfg_shift_en) begin
      shadow <= {bus.cfg_din, shadow[CFG_W-1:1]};
    end else if (bus.cfg_load) begin
      active    <= shadow;
      cfg_valid <= 1'b1;
    end
  end

  assign lits = {bus.in_flb, bus.uim};

  for (genvar g = 0; g < NUM_PT; g++) begin : g_pt
    pt_eval #(.IN_W(IN_W)) u_pt (
      .fuses (active[g*PT_W +: PT_W]),
      .lits  (lits),
      .pt    (pt[g])
    );
  end

  assign ctl        = active[CFG_W-1 -: CTL_W];
  assign sum_mask   = ctl[NUM_PT-1:0];
  assign tail       = ctl[CTL_W-1:NUM_PT];
  assign mode       = mc_mode_e'(tail[CTL_MODE +: 2]);
  assign ce_en      = tail[CTL_CE];
  assign sclr_en    = tail[CTL_SCLR];
  assign cas_in_en  = tail[CTL_CAS_IN];
  assign cas_out_en = tail[CTL_CAS_OUT];
  assign xor_inv    = tail[CTL_XOR_INV];
  assign fb_sel     = tail[CTL_FB_SEL];
  assign oe_sel     = tail[CTL_OE_SEL +: 3];

  // A cell that forwards its sum down the cascade gives up its own use of it
  assign sum_raw   = (|(pt & sum_mask)) | (bus.casin & cas_in_en);
  assign local_sum = cas_out_en ? 1'b0 : sum_raw;
  assign d         = local_sum ^ xor_inv;

  always_ff @(posedge gclk or posedge gclr) begin
    if (gclr) begin
      q <= 1'b0;
    end else if (sclr_en & pt[NUM_PT-2]) begin
      q <= 1'b0;
    end else if (ce_en & ~pt[NUM_PT-1]) begin
      q <= q;
    end else begin
      unique case (mode)
        MODE_D:    q <= d;
        MODE_T:    q <= q ^ d;
        MODE_SR:   q <= pt[0] ? 1'b0 : (d ? 1'b1 : q);
        MODE_COMB: q <= q;
      endcase
    end
  end

  always_comb begin
    oe_tab                 = '0;
    oe_tab[NUM_GOE-1:0]    = bus.goe;
    oe_tab[OE_ALWAYS]      = 1'b1;
    oe_tab[OE_OFF]         = 1'b0;
  end

  assign bus.pad       = (mode == MODE_COMB) ? d : q;
  assign bus.mc_fb     = fb_sel ? d : q;
  assign bus.mc_flb    = ~bus.pad;
  assign bus.pad_oe    = cfg_valid & oe_tab[oe_sel];
  assign bus.casout    = cas_out_en ? sum_raw : 1'b0;
  assign bus.cfg_valid = cfg_valid;

`ifdef MC_CFG_READBACK_EN
  assign bus.cfg_dout = shadow[0];
`else
  assign bus.cfg_dout = 1'b0;
`endif

endmodule
